buffer_stream_reader: RTL

Read-side controller for the 32-bit auto-addressed packet buffer. On a `start` pulse it pulls words from the buffer (`rd_en` out, `data_av`/word in), serialises them MSB-first into an 8-bit valid/ready byte stream, and stops after exactly `byte_len` bytes. It sits between the payload buffer and the byte-oriented UDP/TCP transmit framer, and pairs with the buffer's write-side producer.

---
 rtl/buffer_stream_reader.sv | 105 ++++++++++
 1 files changed

// File: rtl/buffer_stream_reader.sv
// buffer_stream_reader: pulls 32-bit words from the packet buffer and
// serialises them MSB-first into an 8-bit valid/ready byte stream,
// stopping after exactly byte_len bytes.
module buffer_stream_reader #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,      // synchronous, active low
  input  logic             start_i,
  input  logic [LEN_W-1:0] byte_len_i,
  output logic             rd_en_o,
  input  logic [31:0]      data_in_i,
  input  logic             data_av_i,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      retry_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [2:0]       word_left_q, word_left_d;
  logic [31:0]      shift_q, shift_d;
  logic [15:0]      retry_q, retry_d;

  // State and datapath registers; reset clears everything so out_data reads 0.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      word_left_q <= '0;
      shift_q     <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_left_q <= word_left_d;
      shift_q     <= shift_d;
      retry_q     <= retry_d;
    end
  end

  // Next-state logic: fetch a word, drain up to four bytes of it, repeat.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_left_d = word_left_q;
    shift_d     = shift_q;
    retry_d     = retry_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          remaining_d = byte_len_i;
          retry_d     = '0;
          state_d     = (byte_len_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (data_av_i) begin
          shift_d     = data_in_i;
          // A short final word only contributes its top `remaining` bytes.
          word_left_d = (remaining_q >= LEN_W'(4)) ? 3'd4 : remaining_q[2:0];
          state_d     = S_SEND;
        end else begin
          // Buffer was empty: count it and try again.
          if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      S_SEND: begin
        if (out_ready_i) begin
          shift_d     = {shift_q[23:0], 8'h00};
          remaining_d = remaining_q - LEN_W'(1);
          word_left_d = word_left_q - 3'd1;
          if (remaining_q == LEN_W'(1))   state_d = S_DONE;
          else if (word_left_q == 3'd1)   state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so they hold while stalled.
  assign rd_en_o     = (state_q == S_FETCH);
  assign out_valid_o = (state_q == S_SEND);
  assign out_data_o  = shift_q[31:24];
  assign out_last_o  = out_valid_o && (remaining_q == LEN_W'(1));
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign retry_cnt_o = retry_q;

endmodule
